// File: rtl/stream_sink.sv
// Stream sink: accepts beats under a configurable ready pattern, checks for an
// incrementing data sequence and flags upstream protocol violations.
module stream_sink #(
  parameter int unsigned G_DATA_SIZE = 8,
  parameter int unsigned G_CNT_SIZE  = 16,
  parameter logic [15:0] G_SEED      = 16'hACE1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic [G_DATA_SIZE-1:0] s_data_i,
  input  logic [1:0]             mode_i,
  output logic [G_CNT_SIZE-1:0]  count_o,
  output logic [G_CNT_SIZE-1:0]  err_cnt_o,
  output logic                   proto_err_o
);

  // An all-zero LFSR would lock up, so a zero seed is forced to 1.
  localparam logic [15:0] SEED = (G_SEED == 16'h0000) ? 16'h0001 : G_SEED;

  typedef enum logic [1:0] {
    MODE_ALWAYS = 2'b00,
    MODE_NEVER  = 2'b01,
    MODE_RANDOM = 2'b10,
    MODE_ALT    = 2'b11
  } mode_e;

  logic [15:0]            lfsr_q, lfsr_d;
  logic                   ready_q, ready_d;
  logic [G_DATA_SIZE-1:0] exp_q, exp_d;
  logic [G_CNT_SIZE-1:0]  count_q, count_d;
  logic [G_CNT_SIZE-1:0]  err_q, err_d;
  logic                   proto_q, proto_d;
  logic                   stall_q, stall_d;
  logic [G_DATA_SIZE-1:0] hist_data_q, hist_data_d;
  logic                   feedback;
  logic                   accept;
  logic                   violation;

  always_comb begin
    feedback    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d      = {lfsr_q[14:0], feedback};
    accept      = s_valid_i & ready_q;

    ready_d = 1'b0;
    case (mode_e'(mode_i))
      MODE_ALWAYS: ready_d = 1'b1;
      MODE_NEVER:  ready_d = 1'b0;
      MODE_RANDOM: ready_d = lfsr_d[0];
      MODE_ALT:    ready_d = ~ready_q;
      default:     ready_d = 1'b0;
    endcase

    count_d = count_q;
    err_d   = err_q;
    exp_d   = exp_q;
    if (accept) begin
      if (count_q != '1) count_d = count_q + 1'b1;
      if (s_data_i == exp_q) begin
        exp_d = exp_q + 1'b1;
      end else begin
        // Resynchronise to the received value so one gap costs one error.
        exp_d = s_data_i + 1'b1;
        if (err_q != '1) err_d = err_q + 1'b1;
      end
    end

    // A stalled beat must be presented again unchanged on the next cycle.
    stall_d     = s_valid_i & ~ready_q;
    hist_data_d = s_data_i;
    violation   = stall_q & (~s_valid_i | (s_data_i != hist_data_q));
    proto_d     = proto_q | violation;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q      <= SEED;
      ready_q     <= 1'b0;
      exp_q       <= '0;
      count_q     <= '0;
      err_q       <= '0;
      proto_q     <= 1'b0;
      stall_q     <= 1'b0;
      hist_data_q <= '0;
    end else begin
      lfsr_q      <= lfsr_d;
      ready_q     <= ready_d;
      exp_q       <= exp_d;
      count_q     <= count_d;
      err_q       <= err_d;
      proto_q     <= proto_d;
      stall_q     <= stall_d;
      hist_data_q <= hist_data_d;
    end
  end

  assign s_ready_o   = ready_q;
  assign count_o     = count_q;
  assign err_cnt_o   = err_q;
  assign proto_err_o = proto_q;

endmodule

// File: tb/tb_stream_sink.sv
// Directed bench for stream_sink: a default instance plus a narrow-counter,
// zero-seed instance sharing the same stimulus.
module tb_stream_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic [1:0]  mode = 2'b00;

  logic        s_ready;
  logic [15:0] count;
  logic [15:0] err_cnt;
  logic        proto_err;

  logic        s_ready_s;
  logic [2:0]  count_s;
  logic [2:0]  err_cnt_s;
  logic        proto_err_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_sink dut (
    .clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .s_data_i(s_data), .mode_i(mode), .count_o(count), .err_cnt_o(err_cnt),
    .proto_err_o(proto_err)
  );

  stream_sink #(.G_DATA_SIZE(8), .G_CNT_SIZE(3), .G_SEED(16'h0000)) dut_s (
    .clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_ready_o(s_ready_s),
    .s_data_i(s_data), .mode_i(mode), .count_o(count_s), .err_cnt_o(err_cnt_s),
    .proto_err_o(proto_err_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] m);
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = 8'h00;
    mode = m;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    s_valid = 1'b1;
    s_data = d;
    step();
    s_valid = 1'b0;
  endtask

  logic       acc;
  logic       exp_rdy;
  logic [7:0] nxt;
  int         cyc;

  initial begin
    // Mode 00: back-to-back 0..9
    do_reset(2'b00);
    check("rst_ready", s_ready, 0);
    check("rst_count", count, 0);
    check("rst_err", err_cnt, 0);
    check("rst_proto", proto_err, 0);
    step();
    check("m00_ready_first_edge", s_ready, 1);
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_data = 8'(i);
      step();
    end
    s_valid = 1'b0;
    step();
    check("m00_count", count, 10);
    check("m00_err", err_cnt, 0);
    check("m00_proto", proto_err, 0);
    check("sat_count_small", count_s, 7);
    $display("txn mode00 seq0..9 count=%0d err=%0d", count, err_cnt);

    // Mode 00: 0,1,2,7,8 -> one error with resync
    do_reset(2'b00);
    step();
    send(8'd0); send(8'd1); send(8'd2);
    check("gap_err_before", err_cnt, 0);
    send(8'd7);
    check("gap_err_at7", err_cnt, 1);
    send(8'd8);
    check("gap_err_after8", err_cnt, 1);
    check("gap_count", count, 5);
    $display("txn mode00 seq0,1,2,7,8 count=%0d err=%0d", count, err_cnt);

    // Error counter saturation on the narrow instance
    do_reset(2'b00);
    step();
    for (int i = 0; i < 9; i++) send(8'd5);
    check("rep_err", err_cnt, 9);
    check("sat_err_small", err_cnt_s, 7);
    check("sat_count_small2", count_s, 7);
    $display("txn mode00 nine mismatches err=%0d err_small=%0d", err_cnt, err_cnt_s);

    // Mode 10: LFSR-driven ready, then 300 held beats across the 255->0 wrap
    do_reset(2'b10);
    step(); check("lfsr_rdy1", s_ready, 1); check("seed0_rdy1", s_ready_s, 0);
    step(); check("lfsr_rdy2", s_ready, 1);
    step(); check("lfsr_rdy3", s_ready, 1);
    step(); check("lfsr_rdy4", s_ready, 0);
    for (int i = 5; i <= 10; i++) step();
    check("seed0_rdy10", s_ready_s, 0);
    step();
    check("seed0_rdy11", s_ready_s, 1);
    cyc = 0;
    for (int i = 0; i < 300; i++) begin
      s_valid = 1'b1;
      s_data = 8'(i);
      do begin
        acc = s_ready;
        step();
        cyc++;
      end while (!acc && cyc < 4000);
    end
    s_valid = 1'b0;
    step();
    if (cyc >= 4000) check("m10_timeout", 1, 0);
    check("m10_count", count, 300);
    check("m10_err", err_cnt, 0);
    check("m10_proto", proto_err, 0);
    $display("txn mode10 300 beats cycles=%0d count=%0d err=%0d", cyc, count, err_cnt);

    // Mode 01: data changed while stalled
    do_reset(2'b01);
    step();
    check("m01_ready", s_ready, 0);
    s_valid = 1'b1; s_data = 8'h11;
    step();
    check("proto_stall_ok", proto_err, 0);
    s_data = 8'h12;
    step();
    check("proto_set", proto_err, 1);
    s_valid = 1'b0;
    step(); step(); step();
    check("proto_sticky", proto_err, 1);
    check("m01_count", count, 0);
    $display("txn mode01 data change proto=%0d count=%0d", proto_err, count);

    // Mode 11: alternating ready with continuous valid
    do_reset(2'b11);
    step();
    check("m11_first", s_ready, 1);
    exp_rdy = 1'b1;
    nxt = 8'd0;
    s_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      s_data = nxt;
      acc = exp_rdy;
      step();
      exp_rdy = ~exp_rdy;
      check("m11_toggle", s_ready, exp_rdy);
      if (acc) nxt = nxt + 8'd1;
    end
    s_valid = 1'b0;
    check("m11_count", count, 5);
    check("m11_err", err_cnt, 0);
    check("m11_proto", proto_err, 0);
    $display("txn mode11 10 cycles count=%0d", count);

    // Asynchronous reset during a stalled beat
    do_reset(2'b00);
    step();
    send(8'd0); send(8'd1); send(8'd5);
    mode = 2'b01;
    s_valid = 1'b1; s_data = 8'd6;
    step();
    s_data = 8'd7;
    step();
    check("pre_rst_count", count, 4);
    check("pre_rst_err", err_cnt, 1);
    check("pre_rst_ready", s_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("async_ready", s_ready, 0);
    check("async_count", count, 0);
    check("async_err", err_cnt, 0);
    check("async_proto", proto_err, 0);
    s_valid = 1'b0;
    mode = 2'b00;
    step();
    check("in_rst_ready", s_ready, 0);
    rst = 1'b0;
    step();
    check("post_rst_ready", s_ready, 1);
    send(8'd0); send(8'd1);
    check("post_rst_count", count, 2);
    check("post_rst_err", err_cnt, 0);
    check("post_rst_proto", proto_err, 0);
    $display("txn async reset restart count=%0d err=%0d", count, err_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
